apb_reg_slave: RTL

Parametrised APB4 completer that terminates the psel/penable/pwrite/paddr/pwdata/prdata bus and exposes a bank of word-addressed registers to the design. It extends the basic APB signal set with pready (programmable wait states), pslverr (decode, alignment and read-only errors) and pstrb (byte-lane writes). It also runs a phase FSM that flags protocol violations. It sits between the APB bus and the block's control/status logic and is the DUT target for RAL register-model tests.

---
 rtl/apb_reg_slave.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/apb_reg_slave.sv
// APB4 completer exposing a bank of word-addressed registers with byte strobes,
// programmable wait states, error responses and a sticky protocol-violation flag.
module apb_reg_slave #(
    parameter int                  ADDR_W      = 32,
    parameter int                  DATA_W      = 32,
    parameter int                  NUM_REGS    = 8,
    parameter logic [ADDR_W-1:0]   BASE_ADDR   = '0,
    parameter int                  WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK     = 8'hC0
) (
    input  logic                       pclk,
    input  logic                       presetn,
    input  logic                       psel,
    input  logic                       penable,
    input  logic                       pwrite,
    input  logic [ADDR_W-1:0]          paddr,
    input  logic [DATA_W-1:0]          pwdata,
    input  logic [DATA_W/8-1:0]        pstrb,
    output logic [DATA_W-1:0]          prdata,
    output logic                       pready,
    output logic                       pslverr,
    output logic [NUM_REGS*DATA_W-1:0] reg_q,
    input  logic [NUM_REGS*DATA_W-1:0] sts_in,
    output logic [NUM_REGS-1:0]        wr_pulse,
    output logic                       proto_err
);

    localparam int                BYTES     = DATA_W / 8;
    localparam int                IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(BYTES);
    localparam logic [ADDR_W-1:0] SPAN      = ADDR_W'(NUM_REGS * BYTES);
    localparam logic [3:0]        WAIT_LAST = 4'(WAIT_STATES);

    // The state names the bus phase seen on the previous edge: SETUP means the
    // current cycle is the first access cycle, ACCESS means a wait-state continuation.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t              state_reg;
    logic [3:0]          wcnt_reg;
    logic                proto_err_reg;

    logic [ADDR_W-1:0]   off;
    logic [IDX_W-1:0]    idx;
    logic                in_range;
    logic                aligned;
    logic                ro_hit;
    logic                err;
    logic                access;
    logic                bus_ok;
    logic                commit;
    logic                rd_ok;
    logic [DATA_W-1:0]   rw_words  [NUM_REGS];
    logic [DATA_W-1:0]   sts_words [NUM_REGS];

    // Unsigned subtraction makes addresses below BASE_ADDR wrap far out of range.
    assign off      = paddr - BASE_ADDR;
    assign idx      = IDX_W'(off / STRIDE);
    assign in_range = (off < SPAN);
    assign aligned  = ((off % STRIDE) == '0);
    assign ro_hit   = in_range & RO_MASK[idx];
    assign err      = !in_range | !aligned | (pwrite & ro_hit);

    assign access   = (state_reg != ST_IDLE);
    assign bus_ok   = psel & penable;
    assign pready   = access & (wcnt_reg == WAIT_LAST);
    assign pslverr  = pready & err;
    assign commit   = pready & bus_ok & pwrite & !err;
    assign rd_ok    = pready & !pwrite & !err;
    assign prdata   = rd_ok ? (ro_hit ? sts_words[idx] : rw_words[idx]) : '0;

    assign proto_err = proto_err_reg;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_reg     <= ST_IDLE;
            wcnt_reg      <= '0;
            proto_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    wcnt_reg <= '0;
                    if (penable) begin
                        proto_err_reg <= 1'b1;
                    end else if (psel) begin
                        state_reg <= ST_SETUP;
                    end
                end
                default: begin
                    if (!bus_ok) begin
                        // Master abandoned the transfer: flag it and drop back without committing.
                        proto_err_reg <= 1'b1;
                        state_reg     <= ST_IDLE;
                        wcnt_reg      <= '0;
                    end else if (pready) begin
                        state_reg <= ST_IDLE;
                        wcnt_reg  <= '0;
                    end else begin
                        state_reg <= ST_ACCESS;
                        wcnt_reg  <= wcnt_reg + 4'd1;
                    end
                end
            endcase
        end
    end

    genvar gi;
    genvar gb;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            assign sts_words[gi] = sts_in[gi*DATA_W +: DATA_W];

            if (RO_MASK[gi]) begin : g_ro
                assign rw_words[gi]                  = '0;
                assign reg_q[gi*DATA_W +: DATA_W]    = '0;
                assign wr_pulse[gi]                  = 1'b0;
            end else begin : g_rw
                logic [DATA_W-1:0] word_reg;
                logic              pulse_reg;
                logic              hit;

                assign hit = commit && (idx == IDX_W'(gi));

                for (gb = 0; gb < BYTES; gb++) begin : g_lane
                    always_ff @(posedge pclk or negedge presetn) begin
                        if (!presetn) begin
                            word_reg[gb*8 +: 8] <= 8'h00;
                        end else if (hit && pstrb[gb]) begin
                            word_reg[gb*8 +: 8] <= pwdata[gb*8 +: 8];
                        end
                    end
                end

                // Pulses on every committed write, including an all-zero strobe.
                always_ff @(posedge pclk or negedge presetn) begin
                    if (!presetn) begin
                        pulse_reg <= 1'b0;
                    end else begin
                        pulse_reg <= hit;
                    end
                end

                assign rw_words[gi]               = word_reg;
                assign reg_q[gi*DATA_W +: DATA_W] = word_reg;
                assign wr_pulse[gi]               = pulse_reg;
            end
        end
    endgenerate

endmodule
